// File: rtl/aes_req_scheduler.sv
// Round-robin front end that shares one AES encipher engine between
// NUM_REQ requesters. It sequences the engine's next/ready protocol, runs a
// watchdog on each operation, and returns results tagged with the requester
// ID. dbg_state exposes the FSM state to checkers.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. A valid side holds its payload stable until that
// edge. A request may drop its valid before it is accepted; no request
// state is kept between cycles. req_ready is one-hot or zero and is only
// ever raised together with req_valid of the same requester.
module aes_req_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_block,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_id,
    output logic [127:0]           resp_block,
    output logic                   resp_error,
    output logic                   eng_next,
    output logic [127:0]           eng_block,
    input  logic                   eng_ready,
    input  logic [127:0]           eng_result,
    output logic                   busy,
    output logic [15:0]            done_count,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [1:0]   r_last_grant;
    logic [1:0]   r_id;
    logic [7:0]   r_wd;
    logic [127:0] r_eng_block;
    logic [127:0] r_resp_block;
    logic         r_resp_error;
    logic [15:0]  r_done_count;

    logic [1:0]   w_cand;
    logic [1:0]   w_winner;
    logic         w_found;
    logic         w_grant;
    logic         w_timeout;

    // Round-robin search: first valid requester after the last one granted.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = 2'((int'(r_last_grant) + k) % NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && (w_cand == 2'(i)) && req_valid[i]) begin
                    w_found  = 1'b1;
                    w_winner = w_cand;
                end
            end
        end
    end

    // Grant only from IDLE with keys loaded and the engine idle; reset masks it.
    assign w_grant   = (r_state == S_IDLE) && !reset && key_valid && eng_ready && w_found;
    // Fires on the last counted cycle so the response lands exactly TIMEOUT
    // cycles after WAIT_BUSY is entered.
    assign w_timeout = (r_wd >= 8'(TIMEOUT - 1));

    // One-hot accept towards the winning requester, combinational in the grant cycle.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant && (w_winner == 2'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a completed engine wins over a coincident timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_grant) w_next_state = S_START;
            S_START:     w_next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (w_timeout)       w_next_state = S_RESP;
                else if (!eng_ready) w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (eng_ready || w_timeout) w_next_state = S_RESP;
            S_RESP:      if (resp_ready) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state, plus registered payloads.
    always_comb begin
        eng_next   = (r_state == S_START);
        resp_valid = (r_state == S_RESP);
        busy       = (r_state != S_IDLE);
        dbg_state  = r_state;
        eng_block  = r_eng_block;
        resp_id    = r_id;
        resp_block = r_resp_block;
        resp_error = r_resp_error;
        done_count = r_done_count;
    end

    // Datapath: request capture, watchdog, response capture and completion count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 2'(NUM_REQ - 1);
            r_id         <= '0;
            r_wd         <= '0;
            r_eng_block  <= '0;
            r_resp_block <= '0;
            r_resp_error <= 1'b0;
            r_done_count <= '0;
        end else begin
            if (w_grant) begin
                r_eng_block  <= req_block[int'(w_winner)*128 +: 128];
                r_id         <= w_winner;
                r_last_grant <= w_winner;
            end
            case (r_state)
                S_START: r_wd <= '0;
                S_WAIT_BUSY: begin
                    r_wd <= r_wd + 8'd1;
                    if (w_timeout) begin
                        r_resp_block <= '0;
                        r_resp_error <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    r_wd <= r_wd + 8'd1;
                    if (eng_ready) begin
                        r_resp_block <= eng_result;
                        r_resp_error <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_block <= '0;
                        r_resp_error <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready && !r_resp_error) begin
                        r_done_count <= r_done_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_req_scheduler.md
Name: aes_req_scheduler

Overview:
- Round-robin scheduler that shares one AES encipher engine between NUM_REQ independent requesters.
- Accepts a 128-bit plaintext block per requester over a valid/ready handshake.
- Sequences the engine's next/ready protocol, enforces a watchdog timeout, and returns the result tagged with the requester ID.
- Sits between client ports and the encipher engine inside the AES core; key expansion is owned elsewhere and signalled via key_valid.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- TIMEOUT, 128, maximum cycles from eng_next to eng_ready rising before an error response is produced; legal range 8..255.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  round keys are loaded and valid; sampled only at grant.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_block  in  NUM_REQ*128  plaintext; requester i uses [i*128 +: 128].
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  2  index of the requester being answered.
- resp_block  out  128  ciphertext; 0 when resp_error=1.
- resp_error  out  1  response produced by watchdog timeout.
- eng_next  out  1  one-cycle start pulse to the engine.
- eng_block  out  128  block presented to the engine; held stable for the whole operation.
- eng_ready  in  1  engine idle/done flag (high when idle, falls after next, rises when done).
- eng_result  in  128  engine output block, valid when eng_ready rises.
- busy  out  1  high in every state except IDLE.
- done_count  out  16  count of completed non-error responses; wraps 0xFFFF->0.

Behaviour:
- Reset values:
  - FSM=IDLE; req_ready=0, resp_valid=0, resp_id=0, resp_block=0, resp_error=0.
  - eng_next=0, eng_block=0, busy=0, done_count=0.
  - Watchdog counter=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation aborts immediately; the engine is not signalled, and the first post-reset grant follows normal rules.
- Grant in IDLE:
  - Eligible when key_valid=1 and eng_ready=1 and some req_valid=1.
  - Winner is the first valid index searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready[winner] is combinational and asserted only in that cycle.
  - On the handshake the scheduler latches req_block slice into eng_block, latches the ID, updates last_grant, and moves to START.
- No grant in IDLE: a requester may drop req_valid without penalty, and no request state is retained.
- FSM states and transitions:
  - IDLE: as above.
  - START: eng_next=1 for exactly one cycle; watchdog cleared; go to WAIT_BUSY.
  - WAIT_BUSY: wait for eng_ready=0, then WAIT_DONE.
  - WAIT_DONE: wait for eng_ready=1; latch eng_result into resp_block with resp_error=0; go to RESP.
  - RESP: resp_valid=1 with resp_id, resp_block, resp_error held stable until resp_ready=1. On acceptance, go to IDLE and increment done_count if resp_error=0.
- Watchdog:
  - Increments every cycle in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT with no completion, go to RESP with resp_error=1, resp_block=0.
  - Engine recovery after a timeout is the core's responsibility; the scheduler then behaves as normal in IDLE.
- Latency:
  - Handshake at cycle T gives eng_next at T+1.
  - eng_ready observed high at cycle D gives resp_valid at D+1.
  - The earliest next grant is the cycle after the resp handshake.
- Simultaneous events:
  - A resp handshake and a pending req_valid in the same cycle: no grant that cycle.
  - key_valid falling after grant does not affect the operation in flight.
- eng_ready=0 while IDLE blocks grants indefinitely.
- resp_id upper bits are 0 when NUM_REQ=2.

Test Plan:
- key_valid=1, engine model using key 000102…0f, req1 pt 00112233445566778899aabbccddeeff -> req_ready[1] for one cycle; eng_next for one cycle at T+1; resp_valid, resp_id=1, resp_block=69c4e0d86a7b0430d8cdb78070b4c55a, resp_error=0; done_count=1.
- After reset, req0 and req1 valid continuously, resp_ready=1 -> grant order 0,1,0,1; eng_next never asserted while busy=1.
- req0 valid with key_valid=0 for 20 cycles -> no req_ready; key_valid raised at cycle C -> req_ready[0] at C.
- Engine model keeps eng_ready low after next, TIMEOUT=128 -> resp_valid with resp_error=1, resp_block=0 exactly 128 cycles after entering WAIT_BUSY; done_count unchanged.
- resp_ready held low 10 cycles with req1 pending -> resp_valid, resp_id, resp_block stable throughout; no req_ready; req1 granted the cycle after the resp handshake.
- reset pulsed during WAIT_DONE -> all outputs at reset values asynchronously; eng_next stays 0; with req0 and req1 both valid after reset, req0 is granted first.
